secuenciador_contador: RTL and testbench
========================================

// Module: secuenciador_contador
// PURPOSE
//   Controller for the 8-bit up/down counter. It drives the counter's up_down/enable, watches conta.
//   Runs a programmed number of triangle sweeps: 0 -> limite, hold, limite -> 0, hold.
//   Sits beside the counter in the same clock domain; counter and controller share clk and rst.
// PARAMETERS
//   ANCHO        8  width of conta and limite
//   ANCHO_PAUSA  8  width of the pausa hold-time field
//   ANCHO_REP    4  width of the repeticiones field
// PORTS
//   clk           in   1            single system clock, rising edge
//   rst           in   1            synchronous, active-high reset
//   start         in   1            1-cycle request; sampled only in IDLE
//   stop          in   1            abort; highest priority after rst
//   limite        in   ANCHO        sweep peak, latched on accepted start
//   pausa         in   ANCHO_PAUSA  hold length, latched on accepted start
//   repeticiones  in   ANCHO_REP    number of sweeps, latched; 0 treated as 1
//   conta         in   ANCHO        counter value fed back from the counter
//   enable        out  1            counter enable
//   up_down       out  1            1 = count up, 0 = count down
//   busy          out  1            high in every state except IDLE
//   done          out  1            1-cycle pulse on sweep-sequence completion
//   fase          out  3            current state code (debug/observe)
// BEHAVIOUR
//   - All control in a synchronous FSM. Outputs are decoded from the state (Moore), except enable.
//   - enable = state_enable & ~stop. The counter therefore freezes in the same cycle stop is seen.
//   - Reset: state IDLE, enable=0, up_down=1, busy=0, done=0, fase=0, all internal regs 0.
//   - rst mid-operation: IDLE on the next edge; no done pulse.
//   - States and codes:
//     IDLE=0, SUBIR=1, PAUSA_ALTA=2, BAJAR=3, PAUSA_BAJA=4, FIN=5.
//   - IDLE (en=0, ud=1): start & ~stop -> latch limite/pausa/repeticiones.
//       If conta >= limite -> PAUSA_ALTA, else -> SUBIR.
//   - SUBIR (en=1, ud=1): when conta == limite-1 (ANCHO+1-bit compare) -> PAUSA_ALTA.
//       The counter reaches limite on that same edge.
//   - PAUSA_ALTA (en=0): timer 0..pausa, so the state lasts pausa+1 cycles. Then:
//       if conta == 0 -> end-of-sweep logic, else -> BAJAR.
//   - BAJAR (en=1, ud=0): when conta == 1 -> end-of-sweep logic. The counter reaches 0 on that edge.
//   - End-of-sweep logic: decrement the sweep count.
//       Remaining == 0 -> FIN; otherwise -> PAUSA_BAJA.
//   - PAUSA_BAJA (en=0): pausa+1 cycles -> SUBIR (or PAUSA_ALTA if limite == 0).
//   - FIN (en=0): done=1 for exactly one cycle -> IDLE.
//   - stop in any non-IDLE state -> IDLE next edge; done is not asserted.
//   - start & stop in the same IDLE cycle: stop wins, start is ignored.
//   - start while busy is ignored. Latched values are unaffected by input changes while busy.
//   - Hold timer reloads to 0 on every entry to a PAUSA state.
//   - Sweep count never wraps below 0.
//   - limite == 0: no counting. Sequence is PAUSA_ALTA / PAUSA_BAJA only, then FIN.
//   - limite == 2^ANCHO-1: SUBIR ends at conta = 254 -> 255, no counter wrap.
// TESTING (bench instantiates the real counter; conta fed back)
//   1. rst=1 for 2 cycles -> enable=0, up_down=1, busy=0, done=0, fase=0.
//   2. limite=5, pausa=2, rep=1, start pulse -> conta 0..5 over 5 en cycles, holds at 5 for 3 cycles.
//      Then 5..0 over 5 cycles, done pulse once, busy low after.
//   3. limite=3, pausa=0, rep=2 -> conta 0,1,2,3,(hold 1),2,1,0,(hold 1),1,2,3,...,0; done after 2nd sweep.
//   4. stop asserted while conta=3 in SUBIR -> enable low same cycle, conta stays 3, IDLE next, no done.
//   5. limite=0, pausa=1, rep=1 -> enable never high, conta stays 0, done after PAUSA_ALTA (2 cycles).
//   6. start with stop high -> ignored; start while busy -> ignored, limite change mid-run has no effect.

Source files
------------

// File: rtl/secuenciador_contador.sv
// secuenciador_contador
// Sequencer for an external 8-bit up/down counter. It runs a programmed
// number of triangle sweeps, 0 -> limite, hold, limite -> 0, hold, by driving
// the counter's enable and up_down lines and watching its value (conta).
// The counter and this sequencer share clk and the synchronous reset.

module secuenciador_contador #(
    parameter int ANCHO       = 8,
    parameter int ANCHO_PAUSA = 8,
    parameter int ANCHO_REP   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [ANCHO-1:0]       limite,
    input  logic [ANCHO_PAUSA-1:0] pausa,
    input  logic [ANCHO_REP-1:0]   repeticiones,
    input  logic [ANCHO-1:0]       conta,
    output logic                   enable,
    output logic                   up_down,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             fase
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SUBIR      = 3'd1;
    localparam logic [2:0] PAUSA_ALTA = 3'd2;
    localparam logic [2:0] BAJAR      = 3'd3;
    localparam logic [2:0] PAUSA_BAJA = 3'd4;
    localparam logic [2:0] FIN        = 3'd5;

    logic [2:0]             estado, estado_sig;
    logic [ANCHO-1:0]       lim_r, lim_sig;
    logic [ANCHO_PAUSA-1:0] pausa_r, pausa_sig;
    logic [ANCHO_PAUSA-1:0] timer, timer_sig;
    logic [ANCHO_REP-1:0]   rep_r, rep_sig;
    logic                   fin_barrido;
    logic [ANCHO:0]         lim_menos_uno;

    // One bit wider than conta so limite == 0 yields an all-ones value that
    // never matches, instead of wrapping to 255 and ending SUBIR early.
    assign lim_menos_uno = {1'b0, lim_r} - {{ANCHO{1'b0}}, 1'b1};

    // Next-state and next-register logic for the sweep sequencer.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        estado_sig  = estado;
        lim_sig     = lim_r;
        pausa_sig   = pausa_r;
        rep_sig     = rep_r;
        timer_sig   = timer;
        fin_barrido = 1'b0;

        case (estado)
            IDLE: begin
                if (start && !stop) begin
                    lim_sig    = limite;
                    pausa_sig  = pausa;
                    rep_sig    = (repeticiones == '0) ? ANCHO_REP'(1) : repeticiones;
                    timer_sig  = '0;
                    estado_sig = (conta >= limite) ? PAUSA_ALTA : SUBIR;
                end
            end
            SUBIR: begin
                // The counter lands on limite on the same edge we leave.
                if ({1'b0, conta} == lim_menos_uno) begin
                    timer_sig  = '0;
                    estado_sig = PAUSA_ALTA;
                end
            end
            PAUSA_ALTA: begin
                if (timer == pausa_r) begin
                    if (conta == '0) fin_barrido = 1'b1;
                    else             estado_sig  = BAJAR;
                end else begin
                    timer_sig = timer + ANCHO_PAUSA'(1);
                end
            end
            BAJAR: begin
                // The counter lands on 0 on the same edge we leave.
                if (conta == ANCHO'(1)) fin_barrido = 1'b1;
            end
            PAUSA_BAJA: begin
                if (timer == pausa_r) begin
                    timer_sig  = '0;
                    estado_sig = (lim_r == '0) ? PAUSA_ALTA : SUBIR;
                end else begin
                    timer_sig = timer + ANCHO_PAUSA'(1);
                end
            end
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase

        // End of one sweep: consume one repetition, saturating at zero.
        if (fin_barrido) begin
            rep_sig    = (rep_r != '0) ? rep_r - ANCHO_REP'(1) : '0;
            timer_sig  = '0;
            estado_sig = (rep_sig == '0) ? FIN : PAUSA_BAJA;
        end

        // Abort overrides everything except reset; no done pulse follows.
        if (stop && estado != IDLE) estado_sig = IDLE;
    end

    // State and latched-parameter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            estado  <= IDLE;
            lim_r   <= '0;
            pausa_r <= '0;
            rep_r   <= '0;
            timer   <= '0;
        end else begin
            estado  <= estado_sig;
            lim_r   <= lim_sig;
            pausa_r <= pausa_sig;
            rep_r   <= rep_sig;
            timer   <= timer_sig;
        end
    end

    // Moore outputs; enable is additionally gated by stop so the counter
    // freezes in the very cycle stop is seen.
    always_comb begin
        enable  = ((estado == SUBIR) || (estado == BAJAR)) && !stop;
        up_down = (estado != BAJAR);
        busy    = (estado != IDLE);
        done    = (estado == FIN);
        fase    = estado;
    end

endmodule

// File: tb/tb_secuenciador_contador.sv
// tb_secuenciador_contador
// Drives the sequencer together with a simple up/down counter whose value is
// fed back as conta. The expected trace of every run is generated from the
// sweep rules (segment lengths and counter values) and checked cycle by cycle.

module tb_secuenciador_contador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] limite = '0;
    logic [7:0] pausa = '0;
    logic [3:0] repeticiones = '0;
    logic [7:0] conta;
    logic       enable, up_down, busy, done;
    logic [2:0] fase;

    typedef struct {
        int fase;
        bit en;
        bit ud;
        bit chk_ud;
        bit dn;
        int conta;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    int   en_cycles = 0;

    always #5 clk = ~clk;

    secuenciador_contador #(.ANCHO(8), .ANCHO_PAUSA(8), .ANCHO_REP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .limite       (limite),
        .pausa        (pausa),
        .repeticiones (repeticiones),
        .conta        (conta),
        .enable       (enable),
        .up_down      (up_down),
        .busy         (busy),
        .done         (done),
        .fase         (fase)
    );

    // The controlled counter, sharing clk and rst with the sequencer.
    always @(posedge clk) begin
        if (rst)         conta <= 8'd0;
        else if (enable) conta <= up_down ? conta + 8'd1 : conta - 8'd1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push(input int f, input bit en, input bit ud, input bit cu,
                        input bit dn, input int c);
        exp_t e;
        e.fase = f; e.en = en; e.ud = ud; e.chk_ud = cu; e.dn = dn; e.conta = c;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle trace after an accepted start, from counter value c0.
    task automatic build(input int c0, input int lim, input int pau, input int rep);
        int r = (rep == 0) ? 1 : rep;
        int c = c0;
        for (int s = 0; s < r; s++) begin
            for (int v = c; v < lim; v++) push(1, 1, 1, 1, 0, v);
            if (c < lim) c = lim;
            for (int t = 0; t <= pau; t++) push(2, 0, 1, 0, 0, c);
            for (int v = c; v > 0; v--) push(3, 1, 0, 1, 0, v);
            c = 0;
            if (s == r - 1) push(5, 0, 1, 0, 1, 0);
            else for (int t = 0; t <= pau; t++) push(4, 0, 1, 0, 0, 0);
        end
        push(0, 0, 1, 1, 0, 0);
    endtask

    // Single compare process: one expected entry per cycle while a run is queued.
    always @(negedge clk) begin
        exp_t e;
        if (done)   done_seen++;
        if (enable) en_cycles++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fase", int'(fase), e.fase);
            check("enable", int'(enable), int'(e.en));
            if (e.chk_ud) check("up_down", int'(up_down), int'(e.ud));
            check("busy", int'(busy), (e.fase != 0) ? 1 : 0);
            check("done", int'(done), int'(e.dn));
            check("conta", int'(conta), e.conta);
        end
    end

    task automatic launch(input int lim, input int pau, input int rep);
        @(posedge clk); #1;
        limite = 8'(lim); pausa = 8'(pau); repeticiones = 4'(rep); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        if (exp_q.size() > 0) exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, e0;

        // 1. Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enable", int'(enable), 0);
        check("rst_up_down", int'(up_down), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fase", int'(fase), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 2. limite=5, pausa=2, one sweep
        d0 = done_seen; e0 = en_cycles;
        launch(5, 2, 1);
        build(0, 5, 2, 1);
        check("pin_t2_len", exp_q.size(), 15);
        check("pin_t2_peak", exp_q[5].conta, 5);
        check("pin_t2_fin", exp_q[13].fase, 5);
        drain();
        check("t2_done_count", done_seen - d0, 1);
        check("t2_en_cycles", en_cycles - e0, 10);

        // 3. limite=3, pausa=0, two sweeps
        d0 = done_seen; e0 = en_cycles;
        launch(3, 0, 2);
        build(0, 3, 0, 2);
        check("pin_t3_len", exp_q.size(), 17);
        check("pin_t3_hold", exp_q[3].conta, 3);
        check("pin_t3_pbaja", exp_q[7].fase, 4);
        drain();
        check("t3_done_count", done_seen - d0, 1);
        check("t3_en_cycles", en_cycles - e0, 12);

        // repeticiones=0 behaves as a single sweep
        d0 = done_seen;
        launch(2, 0, 0);
        build(0, 2, 0, 0);
        check("pin_rep0_len", exp_q.size(), 7);
        drain();
        check("rep0_done_count", done_seen - d0, 1);

        // 4. stop while conta=3 in SUBIR
        launch(5, 1, 1);
        repeat (4) @(negedge clk);
        check("stop_pre_fase", int'(fase), 1);
        check("stop_pre_conta", int'(conta), 3);
        d0 = done_seen;
        stop = 1'b1;
        #1;
        check("stop_enable_same_cycle", int'(enable), 0);
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("stop_fase_idle", int'(fase), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_conta_frozen", int'(conta), 3);
        repeat (3) @(negedge clk);
        check("stop_conta_still", int'(conta), 3);
        check("stop_no_done", done_seen - d0, 0);

        // start with conta already above limite: straight to the high hold
        d0 = done_seen;
        launch(2, 0, 1);
        build(3, 2, 0, 1);
        check("pin_above_len", exp_q.size(), 6);
        drain();
        check("above_done_count", done_seen - d0, 1);

        // 5. limite=0, pausa=1: no counting at all
        pulse_reset();
        d0 = done_seen; e0 = en_cycles;
        launch(0, 1, 1);
        build(0, 0, 1, 1);
        check("pin_t5_len", exp_q.size(), 4);
        check("pin_t5_fin", exp_q[2].fase, 5);
        drain();
        check("t5_en_cycles", en_cycles - e0, 0);
        check("t5_done_count", done_seen - d0, 1);

        // 6a. start together with stop in IDLE is ignored
        @(posedge clk); #1;
        limite = 8'd5; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("startstop_fase", int'(fase), 0);
        check("startstop_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        check("startstop_conta", int'(conta), 0);

        // 6b. start and new parameters while busy are ignored
        d0 = done_seen;
        launch(4, 1, 1);
        build(0, 4, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; limite = 8'd9; pausa = 8'd7; repeticiones = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        drain();
        check("busy_start_done_count", done_seen - d0, 1);

        // reset mid-operation: back to IDLE, no done
        launch(5, 2, 1);
        repeat (7) @(negedge clk);
        d0 = done_seen;
        pulse_reset();
        @(negedge clk);
        check("midrst_fase", int'(fase), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_conta", int'(conta), 0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_seen - d0, 0);

        // full-scale limite: SUBIR ends at 254 -> 255, no wrap
        d0 = done_seen;
        launch(255, 0, 1);
        build(0, 255, 0, 1);
        check("pin_max_len", exp_q.size(), 513);
        check("pin_max_last_up", exp_q[254].conta, 254);
        check("pin_max_peak", exp_q[255].conta, 255);
        drain();
        check("max_done_count", done_seen - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
